spi_mem_responder: RTL

- Bus responder (target side) for the CPU's memory bus.
- Services bus_read/bus_write requests by running single-byte READ (0x03) and WRITE (0x02) transactions on an external SPI SRAM with 16-bit addressing, in SPI mode 0.
- Holds bus_wait high until each transaction completes.
- Sits between the CPU and the chip's SPI pins.

---
 rtl/spi_mem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spi_mem_responder.sv
// spi_mem_responder
// Target-side bus responder that turns single-byte CPU reads and writes into
// SPI mode 0 READ (0x03) / WRITE (0x02) frames on an external SRAM that uses
// 16-bit addressing. bus_wait holds the CPU until the frame has completed.

module spi_mem_responder #(
  parameter int SCLK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_address,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        bus_wait,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Half-period counter wide enough to hold SCLK_HALF-1, never narrower than one bit.
  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);

  logic [1:0]    state;
  logic [CW-1:0] half_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   tx_shift;
  logic [7:0]    rx_shift;
  logic          is_write;

  logic          request;
  logic          half_end;
  logic [31:0]   req_word;

  assign request  = bus_read | bus_write;
  assign half_end = (half_cnt == HALF_LAST);

  // A simultaneous read and write request is treated as a write.
  assign req_word = bus_write ? {8'h02, bus_address, bus_wdata}
                              : {8'h03, bus_address, 8'h00};

  // The CPU is held whenever it is requesting and the frame has not yet finished;
  // once in DONE the held request is acknowledged and never re-issued.
  assign bus_wait = request & (state != DONE);

  // Frame sequencer: latch the request, shift 32 bits MSB first, then hand
  // the read byte to the bus and wait for the request to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      bus_rdata <= 8'h00;
      half_cnt  <= '0;
      bit_cnt   <= 5'd0;
      tx_shift  <= 32'h0;
      rx_shift  <= 8'h00;
      is_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            spi_mosi <= req_word[31];
            tx_shift <= {req_word[30:0], 1'b0};
            is_write <= bus_write;
            bit_cnt  <= 5'd31;
            half_cnt <= '0;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!half_end) begin
            half_cnt <= half_cnt + 1'b1;
          end else begin
            half_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              rx_shift <= {rx_shift[6:0], spi_miso};
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == 5'd0) begin
                state <= FINISH;
              end else begin
                bit_cnt  <= bit_cnt - 1'b1;
                spi_mosi <= tx_shift[31];
                tx_shift <= {tx_shift[30:0], 1'b0};
              end
            end
          end
        end
        FINISH: begin
          spi_cs_n <= 1'b1;
          spi_sclk <= 1'b0;
          spi_mosi <= 1'b0;
          if (!is_write) begin
            bus_rdata <= rx_shift;
          end
          state <= DONE;
        end
        default: begin
          if (!request) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
